// File: rtl/ilv_pkg.sv
// Shared constants and FSM encoding for the WiMAX ping-pong buffer reader.
package ilv_pkg;

    // Coded bits per bank / interleaver block.
    localparam int NCBPS  = 192;
    // Interleaver column count.
    localparam int D      = 16;
    // Interleaver row count.
    localparam int R      = NCBPS / D;
    // Buffer address width.
    localparam int ADDR_W = 9;

    // Reader FSM encoding. Exposed so checkers can bind to the state register.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO that holds {sob, data} pairs between the buffer read port
// and the serial output handshake. The owner guarantees that push is never
// raised when full and pop is never raised when empty.
module skid_fifo2 #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ilv_ppbuf_reader.sv
// Read-side controller of the PPBuffer: waits for a full bank, reads it in
// first-permutation interleaver order (column-major over a D-column array),
// hands the bank back and streams the bits out serially.
//
// Output handshake: a bit transfers in every cycle where out_valid and
// out_ready are both high; out_valid, out_data and out_sob stay stable while
// out_valid is high and out_ready is low, and out_sob marks the first bit of
// a block.
module ilv_ppbuf_reader #(
    parameter int NCBPS  = ilv_pkg::NCBPS,
    parameter int D      = ilv_pkg::D,
    parameter int ADDR_W = ilv_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              bank_full,
    output logic              bank_release,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rd_en,
    input  logic              q,
    output logic              out_data,
    output logic              out_sob,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int ROWS  = NCBPS / D;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (D > 1) ? $clog2(D) : 1;

    ilv_pkg::state_t  state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             rd_d;
    logic             sob_d;
    logic [1:0]       fifo_count;
    logic [1:0]       head;
    logic             pop;
    logic [2:0]       occupancy;
    logic             credit_ok;
    logic             first_issue;
    logic             last_issue;
    logic             row_wrap;

    assign pop = out_valid && out_ready;

    // Bits already queued plus the read whose data lands this cycle, minus the
    // bit leaving now. A new read is only allowed if its data will find room,
    // which lets a full-rate stream run with just two entries.
    assign occupancy = 3'(fifo_count) + 3'(rd_d) - 3'(pop);
    assign credit_ok = occupancy < 3'd2;

    // Read issue is decided in the same cycle as the pop it depends on, so it
    // is combinational from the state register and the credit.
    assign rd_en = (state == ilv_pkg::READ) && credit_ok;

    assign row_wrap    = (row == ROW_W'(ROWS - 1));
    assign first_issue = (row == '0) && (col == '0);
    assign last_issue  = row_wrap && (col == COL_W'(D - 1));

    // D is a power of two, so D*row + col is a shift and an add.
    assign rdaddress = (ADDR_W'(row) << COL_W) + ADDR_W'(col);

    // Buffer read latency stage: the read issued last cycle returns q now.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rd_d  <= 1'b0;
            sob_d <= 1'b0;
        end else begin
            rd_d  <= rd_en;
            sob_d <= rd_en && first_issue;
        end
    end

    // Bank sequencing: start on a full bank, walk rows then columns, release
    // once the final read's data has been captured.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ilv_pkg::IDLE;
            row          <= '0;
            col          <= '0;
            bank_release <= 1'b0;
        end else begin
            bank_release <= 1'b0;
            case (state)
                ilv_pkg::IDLE: begin
                    // A level still high during the release cycle belongs to
                    // the bank just returned, so it is not taken as a new one.
                    if (bank_full && !bank_release) begin
                        state <= ilv_pkg::READ;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                ilv_pkg::READ: begin
                    if (rd_en) begin
                        if (last_issue) begin
                            row   <= '0;
                            col   <= '0;
                            state <= ilv_pkg::DRAIN;
                        end else if (row_wrap) begin
                            row <= '0;
                            col <= col + 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                ilv_pkg::DRAIN: begin
                    // The last data word is being written into the FIFO now.
                    if (rd_d) begin
                        bank_release <= 1'b1;
                        state        <= ilv_pkg::IDLE;
                    end
                end
                default: begin
                    state <= ilv_pkg::IDLE;
                end
            endcase
        end
    end

    skid_fifo2 #(
        .W(2)
    ) u_fifo (
        .clk       (clk),
        .resetN    (resetN),
        .push      (rd_d),
        .push_data ({sob_d, q}),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head[0] & out_valid;
    assign out_sob   = head[1] & out_valid;

endmodule

// File: tb/tb_ilv_ppbuf_reader.sv
// Directed bench for ilv_ppbuf_reader: a behavioural 1-cycle-latency buffer,
// an expected-bit queue built from the bank contents, and latency, credit,
// back-pressure and reset checks.
module tb_ilv_ppbuf_reader;
    import ilv_pkg::*;

    localparam logic [191:0] BASE_BANK = 192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;

    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              bank_full = 1'b0;
    logic              q = 1'b0;
    logic              out_ready = 1'b1;
    logic              bank_release;
    logic              rd_en;
    logic              out_data;
    logic              out_sob;
    logic              out_valid;
    logic [ADDR_W-1:0] rdaddress;

    logic [191:0] bank = '0;
    logic [1:0]   exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_mode = 0;      // 0: always ready, 1: random, 2: driven by the test
    int drive_cyc = 0;
    int first_rd_cyc = 0;
    int sob_cyc = 0;
    int release_cyc = 0;
    int last_pop_cyc = 0;
    int blk_rd = 0;
    int tot_issue = 0;
    int tot_pop = 0;
    int sob_total = 0;
    int rel_cnt = 0;
    int gap_cnt = 0;
    int stall_rd = 0;
    int pop_base = 0;
    bit gap_on = 1'b0;
    bit b2b = 1'b0;
    bit stall_on = 1'b0;

    ilv_ppbuf_reader u_dut (
        .clk          (clk),
        .resetN       (resetN),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .rdaddress    (rdaddress),
        .rd_en        (rd_en),
        .q            (q),
        .out_data     (out_data),
        .out_sob      (out_sob),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: data is valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) q <= bank[rdaddress];
    end

    // Downstream ready driver.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [191:0] mk_bank(input int n);
        return BASE_BANK ^ {6{32'(n) * 32'h9E3779B9}};
    endfunction

    // Monitor and scoreboard, sampled away from the active edge.
    always @(negedge clk) begin
        logic [1:0] e;
        int         exp_addr;
        if (!resetN) begin
            blk_rd = 0;
            gap_on = 1'b0;
        end else begin
            if (rd_en) begin
                exp_addr = D * (blk_rd % R) + blk_rd / R;
                chk("rdaddress", 32'(rdaddress), 32'(exp_addr));
                if (blk_rd == 0) first_rd_cyc = cyc;
                if (gap_on && b2b) chk("release_to_read_gap_le2", 32'(gap_cnt <= 2), 1);
                gap_on = 1'b0;
                blk_rd++;
                tot_issue++;
                if (stall_on) stall_rd++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("queue_nonempty_on_pop", 32'(exp_q.size()), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("bit_sob_data", 32'({out_sob, out_data}), 32'(e));
                end
                if (out_sob) begin
                    sob_cyc = cyc;
                    sob_total++;
                end
                last_pop_cyc = cyc;
                tot_pop++;
            end
            if (bank_release) begin
                chk("reads_per_block", 32'(blk_rd), 32'(NCBPS));
                blk_rd      = 0;
                rel_cnt++;
                release_cyc = cyc;
                gap_cnt     = 1;
                gap_on      = 1'b1;
            end else if (gap_on && !rd_en) begin
                gap_cnt++;
            end
        end
    end

    // Load a bank, queue its expected bits and raise bank_full.
    task automatic start_block(input logic [191:0] b, input bit hold);
        logic [1:0] item;
        bank = b;
        for (int j = 0; j < NCBPS; j++) begin
            item = {1'(j == 0), b[D * (j % R) + j / R]};
            exp_q.push_back(item);
        end
        @(posedge clk); #1;
        bank_full = 1'b1;
        drive_cyc = cyc;
        pop_base  = tot_pop;
        if (!hold) begin
            @(posedge clk); #1;
            bank_full = 1'b0;
        end
    endtask

    task automatic wait_release();
        int r0 = rel_cnt;
        int t = 0;
        while (rel_cnt == r0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("release_seen", 32'(rel_cnt - r0), 1);
    endtask

    task automatic wait_pops(input int n);
        int t = 0;
        while ((tot_pop - pop_base) < n && t < 1000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("reached_mid_block", 32'((tot_pop - pop_base) >= n), 1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("drain_left", 32'(exp_q.size()), 0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 0);
        chk({tag, "_rdaddress"}, 32'(rdaddress), 0);
        chk({tag, "_bank_release"}, 32'(bank_release), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_out_sob"}, 32'(out_sob), 0);
    endtask

    initial begin
        int p0;
        int i0;
        int r0;
        int s0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single bank, no back-pressure: latency and one release pulse.
        start_block(BASE_BANK, 1'b0);
        wait_release();
        drain();
        chk("first_rd_latency", 32'(first_rd_cyc - drive_cyc), 1);
        chk("first_valid_latency", 32'(sob_cyc - drive_cyc), 3);
        chk("release_latency", 32'(release_cyc - drive_cyc), 194);
        chk("last_bit_latency", 32'(last_pop_cyc - drive_cyc), 194);
        chk("release_pulses", 32'(rel_cnt), 1);
        chk("sob_count", 32'(sob_total), 1);

        // Ten back-to-back banks.
        p0 = tot_pop;
        r0 = rel_cnt;
        for (int i = 0; i < 10; i++) begin
            b2b = (i > 0);
            start_block(mk_bank(i + 1), 1'b0);
            wait_release();
        end
        b2b = 1'b0;
        drain();
        chk("b2b_bits", 32'(tot_pop - p0), 1920);
        chk("b2b_releases", 32'(rel_cnt - r0), 10);

        // Random back-pressure.
        ready_mode = 1;
        start_block(BASE_BANK, 1'b0);
        wait_release();
        drain();
        ready_mode = 0;
        @(posedge clk); #1;

        // Long stall mid-block.
        start_block(mk_bank(11), 1'b0);
        wait_pops(100);
        ready_mode = 2;
        @(posedge clk); #1;
        out_ready = 1'b0;
        stall_rd  = 0;
        stall_on  = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        stall_on = 1'b0;
        chk("stall_rd_en", 32'(stall_rd), 0);
        chk("stall_buffered", 32'(tot_issue - tot_pop), 2);
        chk("stall_out_valid", 32'(out_valid), 1);
        out_ready  = 1'b1;
        ready_mode = 0;
        wait_release();
        drain();

        // bank_full held through READ, DRAIN and the release cycle.
        start_block(mk_bank(12), 1'b1);
        wait_release();
        @(posedge clk); #1;
        bank_full = 1'b0;
        i0 = tot_issue;
        repeat (20) @(posedge clk);
        #1;
        chk("held_full_no_restart", 32'(tot_issue - i0), 0);
        drain();

        // Reset in the middle of a block.
        start_block(mk_bank(13), 1'b0);
        wait_pops(100);
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        exp_q.delete();
        r0 = rel_cnt;
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("midreset_no_release", 32'(rel_cnt - r0), 0);

        // Restart after reset.
        s0 = sob_total;
        start_block(mk_bank(14), 1'b0);
        wait_release();
        drain();
        chk("restart_sob", 32'(sob_total - s0), 1);

        repeat (5) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
